// File: rtl/mes_period_acc_if.sv
// Bus bundle for the period-average measurement block: sample stream in,
// averaged measurement and status out.
interface mes_period_acc_if #(
    parameter int SAMPLE_W = 16
);
    logic                       enable;
    logic                       adc_valid;
    logic signed [SAMPLE_W-1:0] adc_data;
    logic                       clr_overrun;
    logic signed [31:0]         MES_OUT_N_int32;
    logic                       period_end;
    logic                       overrun;

    modport master (
        output enable, adc_valid, adc_data, clr_overrun,
        input  MES_OUT_N_int32, period_end, overrun
    );

    modport slave (
        input  enable, adc_valid, adc_data, clr_overrun,
        output MES_OUT_N_int32, period_end, overrun
    );
endinterface

// File: rtl/mes_period_acc.sv
// Accumulates 2^LOG2_N signed ADC samples and publishes their floor average,
// rate-limited by a holdoff counter so the downstream PI loop is not overrun.
module mes_period_acc #(
    parameter int SAMPLE_W = 16,
    parameter int LOG2_N   = 5,
    parameter int HOLDOFF  = 256
) (
    input  logic              clock,
    input  logic              reset,
    mes_period_acc_if.slave   bus
);
    localparam int ACC_W  = SAMPLE_W + LOG2_N;
    localparam int CNT_W  = LOG2_N + 1;
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    localparam logic [CNT_W-1:0]  LAST      = CNT_W'((1 << LOG2_N) - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);

    logic [0:0]               state;
    logic signed [ACC_W-1:0]  acc_p0;
    logic [CNT_W-1:0]         cnt_p0;
    logic [HOLD_W-1:0]        hold;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum;
    logic                     accept;
    logic                     complete;
    logic                     publish;
    logic                     discard;

    // Arithmetic shift gives floor toward minus infinity for negative sums.
    function automatic logic signed [31:0] floor_avg(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] q;
        q = s >>> LOG2_N;
        return 32'(q);
    endfunction

    always_comb begin
        sample_ext = ACC_W'(bus.adc_data);
        sum        = acc_p0 + sample_ext;
        accept     = (state == ACC) && bus.enable && bus.adc_valid;
        complete   = accept && (cnt_p0 == LAST);
        publish    = complete && (hold == '0);
        discard    = complete && (hold != '0);
    end

    // Stage p0 -> outputs: accumulate, then publish or drop on the Nth sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            acc_p0              <= '0;
            cnt_p0              <= '0;
            hold                <= '0;
            bus.MES_OUT_N_int32 <= '0;
            bus.period_end      <= 1'b0;
            bus.overrun         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc_p0 <= '0;
                    cnt_p0 <= '0;
                    if (bus.enable) state <= ACC;
                end
                ACC: begin
                    if (!bus.enable) begin
                        state  <= IDLE;
                        acc_p0 <= '0;
                        cnt_p0 <= '0;
                    end else if (complete) begin
                        acc_p0 <= '0;
                        cnt_p0 <= '0;
                    end else if (accept) begin
                        acc_p0 <= sum;
                        cnt_p0 <= cnt_p0 + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            bus.period_end <= publish;
            if (publish) bus.MES_OUT_N_int32 <= floor_avg(sum);

            // Holdoff runs regardless of enable so a stop/start cannot bypass it
            if (publish)          hold <= HOLD_LOAD;
            else if (hold != '0)  hold <= hold - HOLD_W'(1);

            if (discard)               bus.overrun <= 1'b1;
            else if (bus.clr_overrun)  bus.overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mes_period_acc.sv
// Directed bench for mes_period_acc: default-holdoff instance plus a
// zero-holdoff instance fed the same stream for back-to-back periods.
module tb_mes_period_acc;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   pe_a  = 0;
    int   pe_b  = 0;

    always #5 clock = ~clock;

    mes_period_acc_if #(.SAMPLE_W(16)) ifa ();
    mes_period_acc_if #(.SAMPLE_W(16)) ifb ();

    assign ifb.enable      = ifa.enable;
    assign ifb.adc_valid   = ifa.adc_valid;
    assign ifb.adc_data    = ifa.adc_data;
    assign ifb.clr_overrun = ifa.clr_overrun;

    mes_period_acc #(.SAMPLE_W(16), .LOG2_N(5), .HOLDOFF(256)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa.slave)
    );

    mes_period_acc #(.SAMPLE_W(16), .LOG2_N(5), .HOLDOFF(0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (ifa.period_end) pe_a++;
        if (ifb.period_end) pe_b++;
    endtask

    task automatic smp(input logic signed [15:0] d);
        ifa.adc_valid = 1'b1;
        ifa.adc_data  = d;
        tick();
        ifa.adc_valid = 1'b0;
    endtask

    task automatic run(input int n, input logic signed [15:0] d);
        repeat (n) smp(d);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        ifa.enable      = 1'b0;
        ifa.adc_valid   = 1'b0;
        ifa.adc_data    = '0;
        ifa.clr_overrun = 1'b0;
        idle(2);
        chk("rst_mes", ifa.MES_OUT_N_int32, 32'h0);
        chk("rst_pe",  {31'b0, ifa.period_end}, 32'h0);
        chk("rst_ovr", {31'b0, ifa.overrun}, 32'h0);
        reset = 1'b0;
        ifa.enable = 1'b1;
        tick();

        // Average of +100 with a sample every 4th cycle
        pe_a = 0;
        for (int i = 0; i < 31; i++) begin
            smp(16'sd100);
            idle(3);
        end
        chk("avg_early_pe", pe_a, 0);
        smp(16'sd100);
        chk("avg_pe",  {31'b0, ifa.period_end}, 32'h1);
        chk("avg_mes", ifa.MES_OUT_N_int32, 32'd100);
        chk("avg_pecnt", pe_a, 1);
        tick();
        chk("avg_pe_1cyc", {31'b0, ifa.period_end}, 32'h0);

        // Floor rounding: sum -31 -> -1
        idle(260);
        run(31, -16'sd1);
        smp(16'sd0);
        chk("floor_mes", ifa.MES_OUT_N_int32, 32'hFFFF_FFFF);

        // Full scale both polarities
        idle(260);
        run(32, -16'sd32768);
        chk("fs_neg", ifa.MES_OUT_N_int32, 32'hFFFF_8000);
        idle(260);
        run(32, 16'sd32767);
        chk("fs_pos", ifa.MES_OUT_N_int32, 32'h0000_7FFF);

        // Holdoff: periods 2..9 dropped, period 10 published
        idle(260);
        run(32, 16'sd10);
        chk("ho_first", ifa.MES_OUT_N_int32, 32'd10);
        pe_a = 0;
        run(32, 16'sd20);
        chk("ho_drop_ovr", {31'b0, ifa.overrun}, 32'h1);
        ifa.clr_overrun = 1'b1;
        smp(16'sd20);
        ifa.clr_overrun = 1'b0;
        chk("ho_clr", {31'b0, ifa.overrun}, 32'h0);
        run(30, 16'sd20);
        ifa.clr_overrun = 1'b1;
        smp(16'sd20);
        ifa.clr_overrun = 1'b0;
        chk("ho_set_wins", {31'b0, ifa.overrun}, 32'h1);
        run(32 * 6, 16'sd20);
        chk("ho_no_pe", pe_a, 0);
        chk("ho_mes_hold", ifa.MES_OUT_N_int32, 32'd10);
        run(31, 16'sd30);
        chk("ho_still_none", pe_a, 0);
        smp(16'sd30);
        chk("ho_pub_pe",  {31'b0, ifa.period_end}, 32'h1);
        chk("ho_pub_mes", ifa.MES_OUT_N_int32, 32'd30);
        tick();
        chk("ho_pe_1cyc", {31'b0, ifa.period_end}, 32'h0);

        // Back-to-back ramp on the zero-holdoff instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        pe_b = 0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 32; k++) begin
                smp(16'(32 * p + k));
                if (k == 0 && p > 0)
                    chk("b2b_pe_low", {31'b0, ifb.period_end}, 32'h0);
            end
            chk("b2b_pe",  {31'b0, ifb.period_end}, 32'h1);
            chk("b2b_mes", ifb.MES_OUT_N_int32, 32'(32 * p + 15));
        end
        chk("b2b_count", pe_b, 3);
        chk("b2b_a_ovr", {31'b0, ifa.overrun}, 32'h1);

        // Reset mid-period clears outputs immediately and discards partial data
        run(10, 16'sd50);
        reset = 1'b1;
        #1;
        chk("mid_rst_mes", ifa.MES_OUT_N_int32, 32'h0);
        chk("mid_rst_pe",  {31'b0, ifa.period_end}, 32'h0);
        chk("mid_rst_ovr", {31'b0, ifa.overrun}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        pe_a = 0;
        run(31, 16'sd60);
        chk("rst_no_early", pe_a, 0);
        smp(16'sd60);
        chk("rst_pub_pe",  {31'b0, ifa.period_end}, 32'h1);
        chk("rst_pub_mes", ifa.MES_OUT_N_int32, 32'd60);

        // Enable dropped after 20 samples discards the partial period
        idle(260);
        run(20, 16'sd70);
        ifa.enable    = 1'b0;
        ifa.adc_valid = 1'b1;
        ifa.adc_data  = 16'sd70;
        tick();
        ifa.adc_valid = 1'b0;
        ifa.enable    = 1'b1;
        tick();
        pe_a = 0;
        run(31, 16'sd80);
        chk("en_no_early", pe_a, 0);
        chk("en_mes_hold", ifa.MES_OUT_N_int32, 32'd60);
        smp(16'sd80);
        chk("en_pub_mes", ifa.MES_OUT_N_int32, 32'd80);
        chk("en_pub_pe",  {31'b0, ifa.period_end}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
